// File: rtl/byte_fifo_ctrl_2k.sv
// byte_fifo_ctrl_2k: pointer and flow-control stage that turns a 2^AW x DW
// dual-port RAM (sync write, one-cycle registered read) into a
// first-word-fall-through byte FIFO. A 2-entry output buffer absorbs the
// RAM read latency so one byte can leave every cycle.
module byte_fifo_ctrl_2k #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_dpra,
  input  logic [DW-1:0] ram_dpo
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra MSB so full (difference == DEPTH) and empty
  // (difference == 0) are distinguishable without a separate flag.
  logic [AW:0]   wr_ptr, rd_ptr, ram_used;
  logic          full, empty, push, pop, issue, inflight, clear;
  logic [1:0]    buf_cnt;
  logic          buf_head;
  logic          buf_tail;
  logic [2:0]    pending;
  logic [DW-1:0] buf_mem [2];

  // Combinational flow control: handshakes, read issue and occupancy.
  // NOTE: every output of this block is a continuous function of current
  // state and inputs with no conditional paths, so no latch can be inferred.
  always_comb begin
    clear     = reset || flush;
    ram_used  = wr_ptr - rd_ptr;
    full      = (ram_used == DEPTH);
    empty     = (ram_used == '0);
    in_ready  = !reset && !flush && !full;
    push      = in_valid && in_ready;
    out_valid = (buf_cnt != 2'd0) && !reset;
    pop       = out_valid && out_ready;
    // Bytes the buffer will hold after this edge, counting the read in flight.
    pending   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    issue     = !empty && (pending < 3'd2);
    buf_tail  = buf_head ^ buf_cnt[0];
    out_data  = buf_mem[buf_head];
    level     = ram_used + {{AW{1'b0}}, inflight} + {{(AW-1){1'b0}}, buf_cnt};
    ram_we    = push;
    ram_a     = wr_ptr[AW-1:0];
    ram_di    = in_data;
    ram_dpra  = rd_ptr[AW-1:0];
  end

  // RAM pointers and the read-in-flight flag; clear drops any pending read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  // Output buffer bookkeeping: head index and occupancy.
  always_ff @(posedge clk) begin
    if (clear) begin
      buf_cnt  <= 2'd0;
      buf_head <= 1'b0;
    end else begin
      if (pop) buf_head <= ~buf_head;
      buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Capture returning RAM data behind the current head. When the buffer is
  // full a capture only happens alongside a pop, so the tail slot is the one
  // being freed and no unpopped byte is overwritten.
  // NOTE: the storage itself is not reset; buf_cnt gates its visibility, so
  // clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (inflight && !clear) buf_mem[buf_tail] <= ram_dpo;
  end

endmodule

// File: tb/tb_byte_fifo_ctrl_2k.sv
// Testbench for byte_fifo_ctrl_2k: behavioural RAM, a queue scoreboard filled
// from accepted pushes and drained by a monitor on every pop, plus directed
// checks for latency, full, flush and reset behaviour.
module tb_byte_fifo_ctrl_2k;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [AW:0]   level;
  logic          ram_we;
  logic [AW-1:0] ram_a, ram_dpra;
  logic [DW-1:0] ram_di, ram_dpo;

  int n_vec = 0;
  int n_fail = 0;
  int pushes_total = 0;
  bit mon_en = 1'b0;
  byte unsigned exp_q[$];
  logic [DW-1:0] ram_mem [2**AW];

  always #5 clk = ~clk;

  byte_fifo_ctrl_2k #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
  );

  // 2048 x 8 block RAM: synchronous write, registered read.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_a] <= ram_di;
    ram_dpo <= ram_mem[ram_dpra];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares occupancy and every popped byte against the model queue,
  // then applies this cycle's clear or accepted push to the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("level", 32'(level), 32'(exp_q.size()));
      if (reset || flush) begin
        check("in_ready_clear", 32'(in_ready), 0);
        if (reset) check("out_valid_reset", 32'(out_valid), 0);
      end else if (exp_q.size() < 2048) begin
        check("in_ready_room", 32'(in_ready), 1);
      end else if (exp_q.size() == 2050) begin
        check("in_ready_full", 32'(in_ready), 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'(out_valid), 0);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (reset || flush) exp_q.delete();
      else if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        pushes_total++;
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!out_valid && level == '0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", 32'(done), 1);
    tick();
  endtask

  initial begin
    int acc, npop, base;
    bit seen_low;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_a", 32'(ram_a), 0);
    check("rst_ram_dpra", 32'(ram_dpra), 0);
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 1);
    tick();

    // Single byte latency: push in cycle 0, out_valid in cycle 3.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    @(negedge clk); check("lat_c1_valid", 32'(out_valid), 0);
    tick();
    @(negedge clk); check("lat_c2_valid", 32'(out_valid), 0);
    tick();
    @(negedge clk);
    check("lat_c3_valid", 32'(out_valid), 1);
    check("lat_c3_data", 32'(out_data), 32'h A5);
    check("lat_c3_level", 32'(level), 1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("lat_pop_level", 32'(level), 0);
    check("lat_pop_valid", 32'(out_valid), 0);
    tick();

    // Streaming 0x00..0xFF with both sides always ready.
    npop = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(i);
      @(negedge clk);
      if (out_valid) npop++;
      if (level > 3) check("stream_level_le3", 32'(level), 3);
      tick();
    end
    check("stream_pops", 32'(npop), 253);
    drain();

    // Fill to full with the consumer stalled.
    acc = 0; seen_low = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (!in_ready) begin
        seen_low = 1'b1;
        break;
      end
      acc++;
      tick();
    end
    check("full_seen", 32'(seen_low), 1);
    check("full_accepts", 32'(acc), 2050);
    check("full_level", 32'(level), 2050);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("full_reready", 32'(in_ready), 1);
    check("full_level_after_pop", 32'(level), 2049);
    tick();
    drain();

    // Random traffic across the address wrap.
    base = pushes_total;
    for (int i = 0; i < 30000 && pushes_total < base + 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    check("random_pushes", 32'(pushes_total - base >= 3000), 1);
    drain();

    // Flush with level 100 and a read in flight.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1; out_ready = 1'b1; in_data = 8'hEE;
    tick();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_pre_level", 32'(level), 100);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_level", 32'(level), 0);
    tick();
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("flush_first_valid", 32'(out_valid), 1);
    check("flush_first_data", 32'(out_data), 32'h3C);
    check("flush_first_level", 32'(level), 1);
    tick();
    drain();

    // Reset for one cycle in the middle of a stream.
    for (int i = 0; i < 60; i++) begin
      in_valid = 1'b1; out_ready = ($urandom_range(0, 1) != 0);
      in_data = 8'($urandom);
      reset = (i == 30);
      if (i == 30) begin
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
      end
      tick();
    end
    reset = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
